rotation_stepper: RTL and testbench

ROTATION_STEPPER -- requirements
Module: rotation_stepper

---
 rtl/rotation_stepper.sv | 136 +++++++++++++
 tb/tb_rotation_stepper.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rotation_stepper.sv
// Rotation angle stepper: synchronizes a slow divider clock, turns its rising
// edges into ticks, and steps a wrapping angle offered through a valid/ready handshake.
module rotation_stepper #(
    parameter int ANGLE_W   = 9,
    parameter int ANGLE_MAX = 359,
    parameter int STEP      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               divided_clk,
    input  logic               enable,
    input  logic               direction,
    output logic               tick,
    output logic [ANGLE_W-1:0] angle,
    output logic               angle_valid,
    input  logic               angle_ready,
    output logic               overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT
    } state_t;

    // One extra bit so angle + STEP and angle + range never overflow.
    localparam logic [ANGLE_W:0] C_MAX  = (ANGLE_W+1)'(ANGLE_MAX);
    localparam logic [ANGLE_W:0] C_MOD  = (ANGLE_W+1)'(ANGLE_MAX + 1);
    localparam logic [ANGLE_W:0] C_STEP = (ANGLE_W+1)'(STEP);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_hist;
    logic               r_tick;
    state_t             r_state;
    logic [ANGLE_W-1:0] r_angle;
    logic               r_valid;
    logic               r_overrun;

    state_t             w_state_next;
    logic [ANGLE_W-1:0] w_angle_next;
    logic               w_valid_next;
    logic               w_overrun_next;
    logic               w_hs;
    logic [ANGLE_W:0]   w_ext;
    logic [ANGLE_W:0]   w_inc_sum;
    logic [ANGLE_W:0]   w_inc;
    logic [ANGLE_W:0]   w_dec;
    logic [ANGLE_W-1:0] w_stepped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= divided_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_tick  <= r_sync2 & ~r_hist;
        end
    end

    assign w_ext     = {1'b0, r_angle};
    assign w_inc_sum = w_ext + C_STEP;
    assign w_inc     = (w_inc_sum > C_MAX) ? (w_inc_sum - C_MOD) : w_inc_sum;
    assign w_dec     = (w_ext < C_STEP) ? (w_ext + C_MOD - C_STEP) : (w_ext - C_STEP);
    // direction only matters on the cycle a tick is actually applied.
    assign w_stepped = direction ? ANGLE_W'(w_dec) : ANGLE_W'(w_inc);
    assign w_hs      = r_valid & angle_ready;

    always_comb begin
        w_state_next   = r_state;
        w_angle_next   = r_angle;
        w_valid_next   = r_valid;
        w_overrun_next = r_overrun;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (r_tick) begin
                    w_angle_next = w_stepped;
                    w_valid_next = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_tick && enable) begin
                    // Coalesce: the offer is refreshed in place and stays valid.
                    w_angle_next = w_stepped;
                    if (!w_hs) begin
                        w_overrun_next = 1'b1;
                    end
                end else begin
                    if (r_tick && !w_hs) begin
                        w_overrun_next = 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_next = 1'b0;
                        w_state_next = enable ? ST_RUN : ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_angle   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_angle   <= w_angle_next;
            r_valid   <= w_valid_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign tick        = r_tick;
    assign angle       = r_angle;
    assign angle_valid = r_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_rotation_stepper.sv
// Randomized bench for rotation_stepper: a per-cycle reference model pushes expected
// outputs into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_rotation_stepper;

    localparam int W       = 9;
    localparam int AMAX    = 359;
    localparam int ASTEP   = 7;
    localparam int NCYCLES = 6000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dc = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b0;
    logic         ready = 1'b0;
    logic         tick;
    logic [W-1:0] angle;
    logic         angle_valid;
    logic         overrun;

    rotation_stepper #(.ANGLE_W(W), .ANGLE_MAX(AMAX), .STEP(ASTEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .divided_clk (dc),
        .enable      (en),
        .direction   (dir),
        .tick        (tick),
        .angle       (angle),
        .angle_valid (angle_valid),
        .angle_ready (ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tick;
        int angle;
        bit valid;
        bit ovr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;
    int   n_ticks_applied = 0;

    function automatic int step_angle(input int a, input bit d);
        if (d) return (a - ASTEP + AMAX + 1) % (AMAX + 1);
        return (a + ASTEP) % (AMAX + 1);
    endfunction

    // Reference model: divided_clk sample history and an offer/mode abstraction.
    initial begin
        bit s0, s1, s2, s3;
        bit tk, t, hs, off, ovr, running;
        int ang;
        s0 = 0; s1 = 0; s2 = 0; s3 = 0;
        tk = 0; off = 0; ovr = 0; running = 0; ang = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                s0 = 0; s1 = 0; s2 = 0; s3 = 0;
                tk = 0; off = 0; ovr = 0; running = 0; ang = 0;
            end else begin
                t  = tk;
                hs = off && ready;
                if (!off) begin
                    if (!running) begin
                        if (en) running = 1;
                    end else if (!en) begin
                        running = 0;
                    end else if (t) begin
                        ang = step_angle(ang, dir);
                        off = 1;
                        n_ticks_applied++;
                    end
                end else if (t && en) begin
                    ang = step_angle(ang, dir);
                    n_ticks_applied++;
                    if (!hs) ovr = 1;
                end else begin
                    if (t && !hs) ovr = 1;
                    if (hs) begin
                        off = 0;
                        running = en;
                    end
                end
                s3 = s2; s2 = s1; s1 = s0; s0 = dc;
                // A tick follows a 0->1 step seen two and three samples back.
                tk = s2 && !s3;
            end
            q.push_back('{tick: tk, angle: ang, valid: off, ovr: ovr});
            started = 1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL queue_empty t=%0t: no expected entry available", $time);
                end else begin
                    e = q.pop_front();
                    if (tick !== e.tick) begin
                        errors++;
                        $display("FAIL tick t=%0t: got %b expected %b", $time, tick, e.tick);
                    end
                    checks++;
                    if (angle_valid !== e.valid) begin
                        errors++;
                        $display("FAIL angle_valid t=%0t: got %b expected %b", $time, angle_valid, e.valid);
                    end
                    checks++;
                    if ($isunknown(angle) || int'(angle) != e.angle) begin
                        errors++;
                        $display("FAIL angle t=%0t: got %0d expected %0d", $time, angle, e.angle);
                    end
                    checks++;
                    if (overrun !== e.ovr) begin
                        errors++;
                        $display("FAIL overrun t=%0t: got %b expected %b", $time, overrun, e.ovr);
                    end
                end
            end
        end
    end

    initial begin
        int half_cnt;
        int ready_pct;
        half_cnt = 4;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        en  = 1'b1;
        for (int c = 0; c < NCYCLES; c++) begin
            @(posedge clk);
            #2;
            if (half_cnt == 0) begin
                dc = ~dc;
                half_cnt = $urandom_range(3, 12);
            end else begin
                half_cnt--;
            end
            // Phase 1: free-running increasing; phase 2: decreasing with backpressure; then mixed.
            if (c < 1500) begin
                dir = 1'b0;
                ready_pct = 100;
            end else if (c < 3000) begin
                dir = 1'b1;
                ready_pct = 30;
            end else begin
                if ($urandom_range(0, 299) == 0) dir = ~dir;
                else if ($urandom_range(0, 19) == 0) dir = ~dir;
                ready_pct = 50;
            end
            ready = ($urandom_range(1, 100) <= ready_pct);
            if (c >= 1500 && $urandom_range(0, 199) == 0) en = ~en;
            if (c >= 1500 && !en && $urandom_range(0, 9) == 0) en = 1'b1;
            rst = (c > 1500 && $urandom_range(0, 599) == 0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (n_ticks_applied < 60) begin
            errors++;
            $display("FAIL activity: got %0d applied ticks expected at least 60", n_ticks_applied);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
